uart_rx_param: RTL
==================

# uart_rx_param

Parametrised 8N1-and-beyond UART receiver with runtime baud divisor, oversampled majority-vote sampling, configurable frame format (data bits, parity, stop bits), per-word error flags and a small output FIFO with valid/ready handshake. It replaces fixed-format, fixed-baud reception in the PDU serial path. It feeds the command parser, which may stall without losing bytes up to FIFO depth.

## Interface
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, 0 none / 1 odd / 2 even
- STOP_BITS, 1, 1 or 2
- OVERSAMPLE, 16, samples per bit, even, >= 8
- DIV_W, 16, width of baud_div
- FIFO_DEPTH, 4, output FIFO entries, power of 2, >= 2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  enable; low behaves exactly as rst
- baud_div  in  DIV_W  clk cycles per oversample tick minus 1; sampled only in IDLE
- uart_rxd  in  1  asynchronous serial line, idle high
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head word when out_valid & out_ready
- out_data  out  DATA_BITS  head word, LSB first on line
- out_perr  out  1  head word parity error (always 0 when PARITY=0)
- out_ferr  out  1  head word framing error (a stop bit sampled 0)
- overrun  out  1  sticky: a completed word was dropped because FIFO full

## Operation
- uart_rxd passes a 2-FF synchronizer (reset value 1); all logic uses the synchronized line rxs.
- Tick generator: counter reloads baud_div latched at leaving IDLE; one-cycle tick when counter reaches 0. Sample counter sc counts ticks 0..OVERSAMPLE-1 per bit.
- Majority vote: samples at sc = OVERSAMPLE/2-1, /2, /2+1; bit value = 2-of-3, decided at sc = OVERSAMPLE/2+1.
- States: DISABLED -> IDLE (unconditional, one cycle after rst/en deassert).
- IDLE: rxs==0 -> START, tick and sc cleared.
- START: voted 0 -> DATA at end of bit (sc wrap); voted 1 -> IDLE immediately (false start, nothing pushed).
- DATA: shift voted bits LSB first; after DATA_BITS bits -> PARITY if PARITY!=0 else STOP.
- PARITY: perr = XOR(data, voted bit) != (PARITY==1 ? 1 : 0), i.e. odd mode requires odd total ones.
- STOP: each of STOP_BITS bits voted; any 0 sets ferr. Word {data, perr, ferr} pushed at the vote of the last stop bit (not at bit end); then IDLE if rxs==1, else BREAK.
- BREAK: wait for rxs==1, then IDLE; no pushes (long-low line yields exactly one ferr word).
- Push with FIFO full: word dropped, overrun set; cleared only by rst/en low.
- Simultaneous push and pop on full FIFO: pop first, push accepted, no overrun.
- Illegal state encoding -> DISABLED.

## Timing
- Reset values: out_valid 0, out_data 0, out_perr 0, out_ferr 0, overrun 0, FIFO empty, state DISABLED.
- Line falling edge to START: 3 clk (2 sync + 1 detect).
- Push occurs at vote of last stop bit; out_valid rises the next cycle. Total frame-start-to-valid ≈ (1+DATA_BITS+P+STOP_BITS-1)·OVERSAMPLE·(baud_div+1) + (OVERSAMPLE/2+1)·(baud_div+1) + ~4 clk.
- FIFO is first-word-fall-through: out_data/out_perr/out_ferr valid whenever out_valid; pop takes effect at the clock edge; next entry visible the following cycle.
- rst or en low mid-frame: partial word discarded, FIFO flushed, next cycle all outputs at reset values.
- baud_div changes mid-frame have no effect until next IDLE.

## Structure
- Shared package uart_pkg: parity encodings (PAR_NONE/ODD/EVEN), state encodings, default OVERSAMPLE.
- Sub-module uart_rx_fifo: synchronous FWFT FIFO, width DATA_BITS+2, depth FIFO_DEPTH, push/pop/full/empty.
- Top holds synchronizer, tick generator, FSM, shift register, overrun flag.

## Test plan
- 8N1, baud_div=3, OVERSAMPLE=16: send 0xA5 then 0x3C, out_ready=1 -> two words 0xA5, 0x3C, perr=ferr=0, overrun=0.
- PARITY=2, 7 data bits: send 0x55 with parity 0 -> perr=0; same with parity 1 -> perr=1, data 0x55 still delivered.
- Glitch: line low for 4 clk only (< half bit) -> no word, state back to IDLE; 1-sample glitch mid-bit of 0xFF -> still 0xFF.
- Stop bit forced 0, then line held low 5 frames -> exactly one word with ferr=1, no further pushes until line high, next clean 0x12 received correctly.
- FIFO_DEPTH=4, out_ready=0, send 5 bytes 0x01..0x05 -> 0x01..0x04 retained in order, overrun=1; drain -> out_valid drops after 4 pops.
- Assert rst mid-data-bit of a frame with 2 words queued -> next cycle out_valid=0, overrun=0; following full frame 0x7E received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: parity modes, FSM states, defaults.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_IDLE     = 3'd1,
        ST_START    = 3'd2,
        ST_DATA     = 3'd3,
        ST_PARITY   = 3'd4,
        ST_STOP     = 3'd5,
        ST_BREAK    = 3'd6
    } state_t;

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word stream: valid/ready handshake carrying data plus per-word error flags.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_perr;
    logic                 out_ferr;

    modport master (
        output out_valid,
        output out_data,
        output out_perr,
        output out_ferr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_perr,
        input  out_ferr,
        output out_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received words until the consumer takes them.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    // A pop frees a slot in the same cycle, so a push on a full FIFO is accepted alongside it.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    // Occupancy and pointers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; only occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Head word is presented as zero while empty so outputs read as reset values.
    always_comb begin
        full  = (count == FULL_CNT);
        empty = (count == '0);
        dout  = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with runtime baud divisor, configurable frame format and output FIFO.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             uart_rxd,
    uart_rx_param_if.master  out_if,
    output logic             overrun
);
    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS);
    localparam int WW   = DATA_BITS + 2;

    localparam logic [SC_W-1:0] SC_A    = SC_W'(OVERSAMPLE/2 - 1);
    localparam logic [SC_W-1:0] SC_B    = SC_W'(OVERSAMPLE/2);
    localparam logic [SC_W-1:0] SC_VOTE = SC_W'(OVERSAMPLE/2 + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic                 kill;
    logic                 sync1;
    logic                 rxs;
    state_t               state;
    state_t               state_nx;
    logic                 active;
    logic [DIV_W-1:0]     div_q;
    logic [DIV_W-1:0]     tick_cnt;
    logic                 tick;
    logic [SC_W-1:0]      sc;
    logic                 smp_a;
    logic                 smp_b;
    logic                 vote;
    logic                 vote_stb;
    logic                 bit_end;
    logic [BC_W-1:0]      bit_cnt;
    logic                 stop_cnt;
    logic                 last_stop;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q;
    logic                 ferr_q;
    logic                 push;
    logic [WW-1:0]        push_word;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [WW-1:0]        head_word;

    assign kill = rst | ~en;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (kill) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            rxs   <= sync1;
        end
    end

    // Oversample tick and vote strobes, valid only while a frame is being received.
    always_comb begin
        active    = (state == ST_START) || (state == ST_DATA) ||
                    (state == ST_PARITY) || (state == ST_STOP);
        tick      = active && (tick_cnt == '0);
        vote      = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
        vote_stb  = tick && (sc == SC_VOTE);
        bit_end   = tick && (sc == SC_LAST);
        last_stop = (STOP_BITS == 1) || stop_cnt;
    end

    // State register; disable or reset forces DISABLED.
    always_ff @(posedge clk) begin
        if (kill)
            state <= ST_DISABLED;
        else
            state <= state_nx;
    end

    // Next-state logic; the frame ends at the last stop-bit vote, not at its bit end.
    always_comb begin
        state_nx = state;
        case (state)
            ST_DISABLED: state_nx = ST_IDLE;
            ST_IDLE:     if (!rxs) state_nx = ST_START;
            ST_START: begin
                if (vote_stb && vote)
                    state_nx = ST_IDLE;
                else if (bit_end)
                    state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt == BC_LAST))
                    state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY:   if (bit_end) state_nx = ST_STOP;
            ST_STOP: begin
                if (vote_stb && last_stop)
                    state_nx = rxs ? ST_IDLE : ST_BREAK;
            end
            ST_BREAK:    if (rxs) state_nx = ST_IDLE;
            default:     state_nx = ST_DISABLED;
        endcase
    end

    // Output decode: push the assembled word at the final stop-bit vote.
    always_comb begin
        push      = (state == ST_STOP) && vote_stb && last_stop;
        push_word = {shreg, perr_q, ferr_q | ~vote};
    end

    // Bit timing and frame bookkeeping; the divisor is re-latched whenever no frame is in progress.
    always_ff @(posedge clk) begin
        if (kill) begin
            div_q    <= '0;
            tick_cnt <= '0;
            sc       <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else if (!active) begin
            div_q    <= baud_div;
            tick_cnt <= baud_div;
            sc       <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else if (tick) begin
            tick_cnt <= div_q;
            sc       <= (sc == SC_LAST) ? '0 : sc + 1'b1;
            if (vote_stb && (state == ST_PARITY))
                perr_q <= (((^shreg) ^ vote) != (PARITY == PAR_ODD));
            if (vote_stb && (state == ST_STOP) && !vote)
                ferr_q <= 1'b1;
            if (bit_end && (state == ST_DATA))
                bit_cnt <= bit_cnt + 1'b1;
            if (bit_end && (state == ST_STOP))
                stop_cnt <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt - 1'b1;
        end
    end

    // Vote samples and LSB-first data shift register.
    always_ff @(posedge clk) begin
        if (tick && (sc == SC_A))
            smp_a <= rxs;
        if (tick && (sc == SC_B))
            smp_b <= rxs;
        if (vote_stb && (state == ST_DATA))
            shreg <= {vote, shreg[DATA_BITS-1:1]};
    end

    // Sticky overrun: a word arrived with no room and no simultaneous pop.
    always_ff @(posedge clk) begin
        if (kill)
            overrun <= 1'b0;
        else if (push && fifo_full && !pop)
            overrun <= 1'b1;
    end

    assign pop = ~fifo_empty & out_if.out_ready;

    uart_rx_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (kill),
        .push  (push),
        .pop   (pop),
        .din   (push_word),
        .dout  (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_if.out_valid = ~fifo_empty;
    assign out_if.out_data  = head_word[WW-1:2];
    assign out_if.out_perr  = head_word[1];
    assign out_if.out_ferr  = head_word[0];

endmodule
